// File: rtl/ex_pipeline_if.sv
// ex_pipeline_if
//   Bundles every non-clock/reset signal of the EX stage.
//   slave  : the EX stage (ex_pipeline). It consumes the ID/EX fields and the
//            WB forwarding path, and it drives the EX/MA register outputs plus
//            the combinational branch/stall outputs.
//   master : the surrounding pipeline. It drives ID/EX + WB and observes the
//            EX outputs.
//   ID/EX  : RegWEn_in, MemRW_in, ASel_in, BSel_in, BrEn_in, Jump_in, MulEn_in,
//            WBSel_in[1:0], funct3_in[2:0], ALUSel_in[3:0], pc_in, pcPlus4_in,
//            DataA_in, DataB_in, Imm_in[31:0], AddrA_in, AddrB_in, AddrD_in[4:0]
//   WB     : fwd_RegWEn, fwd_AddrD[4:0], fwd_DataWB[31:0]
//   EX/MA  : RegWEn_out, MemRW_out, WBSel_out, funct3_out, ALU_Result_out,
//            DataW_out, pcPlus4_out, AddrD_out
//   comb   : PCSel_out, PCTarget_out[31:0], stall_out
interface ex_pipeline_if;
  logic        RegWEn_in;
  logic        MemRW_in;
  logic        ASel_in;
  logic        BSel_in;
  logic        BrEn_in;
  logic        Jump_in;
  logic        MulEn_in;
  logic [1:0]  WBSel_in;
  logic [2:0]  funct3_in;
  logic [3:0]  ALUSel_in;
  logic [31:0] pc_in;
  logic [31:0] pcPlus4_in;
  logic [31:0] DataA_in;
  logic [31:0] DataB_in;
  logic [31:0] Imm_in;
  logic [4:0]  AddrA_in;
  logic [4:0]  AddrB_in;
  logic [4:0]  AddrD_in;
  logic        fwd_RegWEn;
  logic [4:0]  fwd_AddrD;
  logic [31:0] fwd_DataWB;
  logic        RegWEn_out;
  logic        MemRW_out;
  logic [1:0]  WBSel_out;
  logic [2:0]  funct3_out;
  logic [31:0] ALU_Result_out;
  logic [31:0] DataW_out;
  logic [31:0] pcPlus4_out;
  logic [4:0]  AddrD_out;
  logic        PCSel_out;
  logic [31:0] PCTarget_out;
  logic        stall_out;

  modport slave (
    input  RegWEn_in, MemRW_in, ASel_in, BSel_in, BrEn_in, Jump_in, MulEn_in,
           WBSel_in, funct3_in, ALUSel_in, pc_in, pcPlus4_in, DataA_in,
           DataB_in, Imm_in, AddrA_in, AddrB_in, AddrD_in,
           fwd_RegWEn, fwd_AddrD, fwd_DataWB,
    output RegWEn_out, MemRW_out, WBSel_out, funct3_out, ALU_Result_out,
           DataW_out, pcPlus4_out, AddrD_out, PCSel_out, PCTarget_out, stall_out
  );

  modport master (
    output RegWEn_in, MemRW_in, ASel_in, BSel_in, BrEn_in, Jump_in, MulEn_in,
           WBSel_in, funct3_in, ALUSel_in, pc_in, pcPlus4_in, DataA_in,
           DataB_in, Imm_in, AddrA_in, AddrB_in, AddrD_in,
           fwd_RegWEn, fwd_AddrD, fwd_DataWB,
    input  RegWEn_out, MemRW_out, WBSel_out, funct3_out, ALU_Result_out,
           DataW_out, pcPlus4_out, AddrD_out, PCSel_out, PCTarget_out, stall_out
  );
endinterface

// File: rtl/ex_pipeline.sv
// ex_pipeline
//   RISC-V style execute stage. It forwards operands from EX/MA and WB,
//   runs the ALU and the branch compare, and registers the EX/MA fields.
//   Ports:
//     clk     : rising-edge clock
//     reset_n : asynchronous active-low reset; clears EX/MA and the multiplier
//     bus     : ex_pipeline_if.slave (ID/EX inputs, WB forwarding, EX/MA
//               outputs, PCSel/PCTarget/stall)
//   Build option:
//     EX_MUL_EN : when defined, adds a 32-cycle shift-add multiplier selected
//                 by MulEn_in. It stalls the stage while busy. When undefined,
//                 MulEn_in is ignored and stall_out is tied low.
module ex_pipeline (
  input logic          clk,
  input logic          reset_n,
  ex_pipeline_if.slave bus
);

  logic [31:0] rs1Fwd;
  logic [31:0] rs2Fwd;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] aluResult;
  logic [31:0] exResult;
  logic        brTaken;
  logic        stall;

  // Forward rs1: an EX/MA ALU result wins over WB; x0 is never forwarded.
  always_comb begin
    rs1Fwd = bus.DataA_in;
    if ((bus.AddrA_in != 5'd0) && bus.RegWEn_out &&
        (bus.AddrD_out == bus.AddrA_in) && (bus.WBSel_out == 2'b01)) begin
      rs1Fwd = bus.ALU_Result_out;
    end else if ((bus.AddrA_in != 5'd0) && bus.fwd_RegWEn &&
                 (bus.fwd_AddrD == bus.AddrA_in)) begin
      rs1Fwd = bus.fwd_DataWB;
    end else begin
      rs1Fwd = bus.DataA_in;
    end
  end

  // Forward rs2 with the same priority as rs1.
  always_comb begin
    rs2Fwd = bus.DataB_in;
    if ((bus.AddrB_in != 5'd0) && bus.RegWEn_out &&
        (bus.AddrD_out == bus.AddrB_in) && (bus.WBSel_out == 2'b01)) begin
      rs2Fwd = bus.ALU_Result_out;
    end else if ((bus.AddrB_in != 5'd0) && bus.fwd_RegWEn &&
                 (bus.fwd_AddrD == bus.AddrB_in)) begin
      rs2Fwd = bus.fwd_DataWB;
    end else begin
      rs2Fwd = bus.DataB_in;
    end
  end

  assign opA = bus.ASel_in ? bus.pc_in  : rs1Fwd;
  assign opB = bus.BSel_in ? bus.Imm_in : rs2Fwd;

  // ALU: shifts use opB[4:0]; unused encodings produce zero.
  always_comb begin
    aluResult = 32'd0;
    case (bus.ALUSel_in)
      4'd0:    aluResult = opA + opB;
      4'd1:    aluResult = opA - opB;
      4'd2:    aluResult = opA << opB[4:0];
      4'd3:    aluResult = {31'd0, ($signed(opA) < $signed(opB))};
      4'd4:    aluResult = {31'd0, (opA < opB)};
      4'd5:    aluResult = opA ^ opB;
      4'd6:    aluResult = opA >> opB[4:0];
      4'd7:    aluResult = $unsigned($signed(opA) >>> opB[4:0]);
      4'd8:    aluResult = opA | opB;
      4'd9:    aluResult = opA & opB;
      4'd10:   aluResult = opB;
      default: aluResult = 32'd0;
    endcase
  end

  // Branch condition always compares the forwarded registers, never pc/imm.
  always_comb begin
    brTaken = 1'b0;
    case (bus.funct3_in)
      3'b000:  brTaken = (rs1Fwd == rs2Fwd);
      3'b001:  brTaken = (rs1Fwd != rs2Fwd);
      3'b100:  brTaken = ($signed(rs1Fwd) <  $signed(rs2Fwd));
      3'b101:  brTaken = ($signed(rs1Fwd) >= $signed(rs2Fwd));
      3'b110:  brTaken = (rs1Fwd <  rs2Fwd);
      3'b111:  brTaken = (rs1Fwd >= rs2Fwd);
      default: brTaken = 1'b0;
    endcase
  end

`ifdef EX_MUL_EN
  typedef enum logic {MUL_IDLE = 1'b0, MUL_BUSY = 1'b1} mulState_t;

  mulState_t   mulState;
  logic [4:0]  mulCnt;
  logic [31:0] mulCand;
  logic [31:0] mulPlier;
  logic [31:0] mulProd;
  logic        mulDone;

  // Multiplier FSM. The capture edge already adds multiplier bit 0, so
  // 31 BUSY cycles finish the 32 iterations. mulDone marks the single
  // cycle in which EX/MA takes the product. It also prevents a restart
  // from the still-held MulEn_in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mulState <= MUL_IDLE;
      mulCnt   <= 5'd0;
      mulCand  <= 32'd0;
      mulPlier <= 32'd0;
      mulProd  <= 32'd0;
      mulDone  <= 1'b0;
    end else begin
      case (mulState)
        MUL_IDLE: begin
          if (mulDone) begin
            mulDone <= 1'b0;
          end else if (bus.MulEn_in) begin
            mulProd  <= opB[0] ? opA : 32'd0;
            mulCand  <= opA << 1;
            mulPlier <= opB >> 1;
            mulCnt   <= 5'd1;
            mulState <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          mulProd  <= mulProd + (mulPlier[0] ? mulCand : 32'd0);
          mulCand  <= mulCand << 1;
          mulPlier <= mulPlier >> 1;
          mulCnt   <= mulCnt + 5'd1;
          if (mulCnt == 5'd31) begin
            mulState <= MUL_IDLE;
            mulDone  <= 1'b1;
          end
        end
        default: begin
          mulState <= MUL_IDLE;
          mulCnt   <= 5'd0;
          mulDone  <= 1'b0;
        end
      endcase
    end
  end

  // Gate with reset_n so stall drops as soon as reset is applied mid-multiply.
  assign stall = reset_n & ((mulState == MUL_BUSY) ||
                            ((mulState == MUL_IDLE) && bus.MulEn_in && !mulDone));
  assign exResult = mulDone ? mulProd : aluResult;
`else
  logic unusedMulEn;

  assign unusedMulEn = bus.MulEn_in;
  assign stall       = 1'b0;
  assign exResult    = aluResult;
`endif

  assign bus.stall_out    = stall;
  assign bus.PCSel_out    = !stall && (bus.Jump_in || (bus.BrEn_in && brTaken));
  assign bus.PCTarget_out = {aluResult[31:1], 1'b0};

  // EX/MA register. A stall inserts a bubble by clearing only the write
  // enables, and every other field holds its value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.RegWEn_out     <= 1'b0;
      bus.MemRW_out      <= 1'b0;
      bus.WBSel_out      <= 2'd0;
      bus.funct3_out     <= 3'd0;
      bus.ALU_Result_out <= 32'd0;
      bus.DataW_out      <= 32'd0;
      bus.pcPlus4_out    <= 32'd0;
      bus.AddrD_out      <= 5'd0;
    end else if (stall) begin
      bus.RegWEn_out <= 1'b0;
      bus.MemRW_out  <= 1'b0;
    end else begin
      bus.RegWEn_out     <= bus.RegWEn_in;
      bus.MemRW_out      <= bus.MemRW_in;
      bus.WBSel_out      <= bus.WBSel_in;
      bus.funct3_out     <= bus.funct3_in;
      bus.ALU_Result_out <= exResult;
      bus.DataW_out      <= rs2Fwd;
      bus.pcPlus4_out    <= bus.pcPlus4_in;
      bus.AddrD_out      <= bus.AddrD_in;
    end
  end

endmodule

// File: tb/tb_ex_pipeline.sv
// tb_ex_pipeline: self-checking bench for ex_pipeline. It combines directed
// cases with randomized ALU/branch/forwarding traffic. A behavioural model
// predicts the EX/MA contents and the branch outputs. Build with +define+EX_MUL_EN
// to exercise the multiplier.
module tb_ex_pipeline;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   assertCount = 0;
  int   failCount = 0;

  // Model of the EX/MA register contents.
  logic        mRegWEn = 1'b0;
  logic        mMemRW = 1'b0;
  logic [1:0]  mWBSel = 2'd0;
  logic [2:0]  mFunct3 = 3'd0;
  logic [31:0] mAlu = 32'd0;
  logic [31:0] mDataW = 32'd0;
  logic [31:0] mPc4 = 32'd0;
  logic [4:0]  mAddrD = 5'd0;

  ex_pipeline_if bus ();

  ex_pipeline dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] aluRef(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh = int'(b % 32);
    ext = {{32{a[31]}}, a};
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a << sh;
      4'd3:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4:    return (a < b) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd6:    return a >> sh;
      4'd7:    return 32'(ext >> sh);
      4'd8:    return a | b;
      4'd9:    return a & b;
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic brRef(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return int'(a) < int'(b);
      3'b101:  return int'(a) >= int'(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Register value seen by an instruction: the newest in-flight ALU write wins.
  function automatic logic [31:0] fwdRef(input logic [4:0] rs, input logic [31:0] regVal);
    if (rs == 5'd0) return regVal;
    if (mRegWEn && (mWBSel == 2'b01) && (mAddrD == rs)) return mAlu;
    if (bus.fwd_RegWEn && (bus.fwd_AddrD == rs)) return bus.fwd_DataWB;
    return regVal;
  endfunction

  task automatic modelReset();
    mRegWEn = 1'b0; mMemRW = 1'b0; mWBSel = 2'd0; mFunct3 = 3'd0;
    mAlu = 32'd0; mDataW = 32'd0; mPc4 = 32'd0; mAddrD = 5'd0;
  endtask

  task automatic checkRegs();
    checkVal("exma_ctl", {19'd0, bus.RegWEn_out, bus.MemRW_out, bus.WBSel_out, bus.funct3_out, bus.AddrD_out},
             {19'd0, mRegWEn, mMemRW, mWBSel, mFunct3, mAddrD});
    checkVal("exma_alu", bus.ALU_Result_out, mAlu);
    checkVal("exma_dataw", bus.DataW_out, mDataW);
    checkVal("exma_pc4", bus.pcPlus4_out, mPc4);
  endtask

  task automatic setIdle();
    bus.RegWEn_in = 1'b0; bus.MemRW_in = 1'b0; bus.ASel_in = 1'b0; bus.BSel_in = 1'b0;
    bus.BrEn_in = 1'b0; bus.Jump_in = 1'b0; bus.MulEn_in = 1'b0; bus.WBSel_in = 2'd0;
    bus.funct3_in = 3'd0; bus.ALUSel_in = 4'd0; bus.pc_in = 32'd0; bus.pcPlus4_in = 32'd0;
    bus.DataA_in = 32'd0; bus.DataB_in = 32'd0; bus.Imm_in = 32'd0;
    bus.AddrA_in = 5'd0; bus.AddrB_in = 5'd0; bus.AddrD_in = 5'd0;
    bus.fwd_RegWEn = 1'b0; bus.fwd_AddrD = 5'd0; bus.fwd_DataWB = 32'd0;
  endtask

  // One non-stalling instruction: check the branch outputs, clock it, check EX/MA.
  task automatic cycle();
    logic [31:0] r1, r2, a, b, res;
    logic expSel;
    #1;
    r1 = fwdRef(bus.AddrA_in, bus.DataA_in);
    r2 = fwdRef(bus.AddrB_in, bus.DataB_in);
    a = bus.ASel_in ? bus.pc_in : r1;
    b = bus.BSel_in ? bus.Imm_in : r2;
    res = aluRef(bus.ALUSel_in, a, b);
    expSel = bus.Jump_in | (bus.BrEn_in & brRef(bus.funct3_in, r1, r2));
    checkVal("stall", {31'd0, bus.stall_out}, 32'd0);
    checkVal("pcsel", {31'd0, bus.PCSel_out}, {31'd0, expSel});
    checkVal("pctarget", bus.PCTarget_out, res & 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    mRegWEn = bus.RegWEn_in; mMemRW = bus.MemRW_in; mWBSel = bus.WBSel_in;
    mFunct3 = bus.funct3_in; mAlu = res; mDataW = r2; mPc4 = bus.pcPlus4_in;
    mAddrD = bus.AddrD_in;
    checkRegs();
  endtask

`ifdef EX_MUL_EN
  // Issue one MUL and hold it until the stage releases it.
  task automatic doMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int stalls;
    bit finished;
    stalls = 0;
    finished = 1'b0;
    setIdle();
    bus.MulEn_in = 1'b1; bus.DataA_in = a; bus.DataB_in = b; bus.RegWEn_in = 1'b1;
    bus.WBSel_in = 2'b01; bus.AddrD_in = rd; bus.Jump_in = 1'b1;
    bus.pcPlus4_in = 32'h0000_4444;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus.stall_out) begin
        stalls++;
        checkVal("mul_pcsel_stall", {31'd0, bus.PCSel_out}, 32'd0);
        @(posedge clk);
        #1;
        mRegWEn = 1'b0;
        mMemRW = 1'b0;
        checkRegs();
      end else begin
        checkVal("mul_pcsel_done", {31'd0, bus.PCSel_out}, 32'd1);
        @(posedge clk);
        #1;
        finished = 1'b1;
        break;
      end
    end
    checkVal("mul_finished", {31'd0, finished}, 32'd1);
    checkVal("mul_stall_cycles", stalls, 32'd32);
    mRegWEn = 1'b1; mMemRW = 1'b0; mWBSel = 2'b01; mFunct3 = 3'd0;
    mAlu = a * b; mDataW = b; mPc4 = 32'h0000_4444; mAddrD = rd;
    checkRegs();
    setIdle();
  endtask
`endif

  initial begin
    logic [31:0] r;
    setIdle();
    modelReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_stall", {31'd0, bus.stall_out}, 32'd0);
    checkRegs();
    @(negedge clk);
    reset_n = 1'b1;

    // ADD wraps modulo 2^32.
    setIdle(); bus.DataA_in = 32'hFFFF_FFFF; bus.BSel_in = 1'b1; bus.Imm_in = 32'd1;
    bus.AddrD_in = 5'd1; cycle();
    checkVal("add_wrap", bus.ALU_Result_out, 32'd0);
    // SRA sign-extends.
    bus.ALUSel_in = 4'd7; bus.DataA_in = 32'h8000_0000; bus.Imm_in = 32'd4; cycle();
    checkVal("sra", bus.ALU_Result_out, 32'hF800_0000);

    // Forwarding: EX/MA x5=0x11 beats WB x5=0x22; x0 never forwards.
    setIdle(); bus.ALUSel_in = 4'd10; bus.BSel_in = 1'b1; bus.Imm_in = 32'h11;
    bus.RegWEn_in = 1'b1; bus.WBSel_in = 2'b01; bus.AddrD_in = 5'd5; cycle();
    bus.ALUSel_in = 4'd0; bus.Imm_in = 32'd0; bus.AddrA_in = 5'd5; bus.DataA_in = 32'h99;
    bus.fwd_RegWEn = 1'b1; bus.fwd_AddrD = 5'd5; bus.fwd_DataWB = 32'h22; cycle();
    checkVal("fwd_exma", bus.ALU_Result_out, 32'h11);
    bus.AddrA_in = 5'd0; bus.DataA_in = 32'h33; bus.RegWEn_in = 1'b0; cycle();
    checkVal("fwd_x0", bus.ALU_Result_out, 32'h33);
    bus.AddrA_in = 5'd5; cycle();
    checkVal("fwd_wb", bus.ALU_Result_out, 32'h22);

    // Branch BLT taken, BLTU not taken.
    setIdle(); bus.BrEn_in = 1'b1; bus.funct3_in = 3'b100; bus.DataA_in = 32'hFFFF_FFFF;
    bus.DataB_in = 32'd1; bus.ASel_in = 1'b1; bus.pc_in = 32'h1000; bus.BSel_in = 1'b1;
    bus.Imm_in = 32'h40;
    #1;
    checkVal("blt_pcsel", {31'd0, bus.PCSel_out}, 32'd1);
    checkVal("blt_target", bus.PCTarget_out, 32'h1040);
    cycle();
    bus.funct3_in = 3'b110;
    #1;
    checkVal("bltu_pcsel", {31'd0, bus.PCSel_out}, 32'd0);
    cycle();

    // JALR clears bit 0 of the target and carries pc+4.
    setIdle(); bus.Jump_in = 1'b1; bus.DataA_in = 32'h103; bus.BSel_in = 1'b1;
    bus.pcPlus4_in = 32'h2004; bus.RegWEn_in = 1'b1; bus.AddrD_in = 5'd1;
    #1;
    checkVal("jalr_target", bus.PCTarget_out, 32'h102);
    checkVal("jalr_pcsel", {31'd0, bus.PCSel_out}, 32'd1);
    cycle();
    checkVal("jalr_pc4", bus.pcPlus4_out, 32'h2004);

`ifdef EX_MUL_EN
    doMul(32'd7, 32'd6, 5'd3);
    checkVal("mul_7x6", bus.ALU_Result_out, 32'd42);
    checkVal("mul_7x6_wen", {31'd0, bus.RegWEn_out}, 32'd1);
    doMul(32'hFFFF_FFFF, 32'd2, 5'd4);
    checkVal("mul_ffx2", bus.ALU_Result_out, 32'hFFFF_FFFE);
    // Reset in the middle of a multiply aborts it.
    setIdle(); bus.MulEn_in = 1'b1; bus.DataA_in = 32'd7; bus.DataB_in = 32'd6;
    bus.RegWEn_in = 1'b1; bus.WBSel_in = 2'b01; bus.AddrD_in = 5'd3;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkVal("rst_mid_stall", {31'd0, bus.stall_out}, 32'd0);
    modelReset();
    checkRegs();
    bus.MulEn_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    doMul(32'd3, 32'd3, 5'd2);
    checkVal("mul_3x3", bus.ALU_Result_out, 32'd9);
`else
    // Without the multiplier, MulEn_in is ignored and ALUSel_in decides.
    setIdle(); bus.MulEn_in = 1'b1; bus.ALUSel_in = 4'd5; bus.DataA_in = 32'hF0F0_1234;
    bus.BSel_in = 1'b1; bus.Imm_in = 32'h0FF0_0004; cycle();
    checkVal("mul_ignored", bus.ALU_Result_out, 32'hFF00_1230);
`endif

    // Random traffic over a small register window to provoke forwarding hits.
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      bus.RegWEn_in = r[0]; bus.MemRW_in = r[1]; bus.ASel_in = r[2]; bus.BSel_in = r[3];
      bus.BrEn_in = r[4]; bus.Jump_in = r[5];
`ifdef EX_MUL_EN
      bus.MulEn_in = 1'b0;
`else
      bus.MulEn_in = r[6];
`endif
      bus.WBSel_in = r[8:7]; bus.funct3_in = r[11:9]; bus.ALUSel_in = r[15:12];
      bus.AddrA_in = {3'd0, r[17:16]}; bus.AddrB_in = {3'd0, r[19:18]};
      bus.AddrD_in = {3'd0, r[21:20]}; bus.fwd_AddrD = {3'd0, r[23:22]};
      bus.fwd_RegWEn = r[24];
      bus.pc_in = $urandom; bus.pcPlus4_in = bus.pc_in + 32'd4;
      bus.DataA_in = $urandom; bus.Imm_in = $urandom; bus.fwd_DataWB = $urandom;
      bus.DataB_in = r[25] ? bus.DataA_in : $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
